// File: rtl/vga_driver.sv
// VGA timing generator and pixel sink: free-running h/v counters, sync decode,
// one-clock-early pixel request and blanking-gated RGB565 output.
module vga_driver #(
  parameter logic [10:0] H_SYNC   = 11'd120,
  parameter logic [10:0] H_BACK   = 11'd64,
  parameter logic [10:0] H_DISP   = 11'd800,
  parameter logic [10:0] H_FRONT  = 11'd56,
  parameter logic [10:0] H_TOTAL  = 11'd1040,
  parameter logic [10:0] V_SYNC   = 11'd6,
  parameter logic [10:0] V_BACK   = 11'd23,
  parameter logic [10:0] V_DISP   = 11'd600,
  parameter logic [10:0] V_FRONT  = 11'd37,
  parameter logic [10:0] V_TOTAL  = 11'd666,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [10:0] HA     = H_SYNC + H_BACK;
  localparam logic [10:0] HA_END = HA + H_DISP;
  localparam logic [10:0] VA     = V_SYNC + V_BACK;
  localparam logic [10:0] VA_END = VA + V_DISP;

  if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_bad_h_total
    $error("vga_driver: H_TOTAL does not match its components");
  end
  if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_bad_v_total
    $error("vga_driver: V_TOTAL does not match its components");
  end

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        run_q;
  logic        h_act, h_req, v_act;

  // Counters hold at 0,0 for the first clock after reset so that the
  // frame_start pulse of the very first frame is a full clock wide.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == H_TOTAL - 11'd1) begin
        h_cnt_d = 11'd0;
        v_cnt_d = (v_cnt_q == V_TOTAL - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
      run_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign h_act = (h_cnt_q >= HA) && (h_cnt_q < HA_END);
  assign h_req = (h_cnt_q >= HA - 11'd1) && (h_cnt_q < HA_END - 11'd1);
  assign v_act = (v_cnt_q >= VA) && (v_cnt_q < VA_END);

  assign vga_hs      = (h_cnt_q < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vga_vs      = (v_cnt_q < V_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vga_en      = h_act && v_act;
  assign data_req    = h_req && v_act;
  assign pixel_xpos  = data_req ? h_cnt_q - (HA - 11'd1) : 11'd0;
  assign pixel_ypos  = data_req ? v_cnt_q - VA : 11'd0;
  assign vga_rgb     = vga_en ? pixel_data : 16'h0000;
  assign frame_start = run_q && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

endmodule
